// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage and the IF/ID
// bundle consumed by decode.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

  localparam ifid_t IFID_RESET = '{
    valid:    1'b0,
    inst:     NOP_INST,
    pc:       32'h0000_0000,
    pc_plus4: INSTR_BYTES
  };

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: fetch drives the byte address, memory returns the
// word combinationally in the same cycle.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;

  modport master (output imem_addr, input imem_inst);
  modport slave  (input imem_addr, output imem_inst);
endinterface

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register with flush (clear valid, load NOP) over hold over load.
module ifid_reg
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hold,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);

  ifid_t q_r;

  // Pipeline register; on flush the pc fields keep their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r <= IFID_RESET;
    end else if (flush) begin
      q_r.valid <= 1'b0;
      q_r.inst  <= NOP_INST;
    end else if (hold) begin
      q_r <= q_r;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills
// the IF/ID register; handles start, stall, redirect/flush, halt and fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'd64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                stall_i,
  input  logic                redirect_i,
  input  logic [31:0]         redirect_pc_i,
  fetch_unit_if.master        imem,
  output logic                ifid_valid_o,
  output logic [31:0]         ifid_inst_o,
  output logic [31:0]         ifid_pc_o,
  output logic [31:0]         ifid_pc_plus4_o,
  output logic                halted_o,
  output logic                fault_o,
  output logic [31:0]         fetch_count_o
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  count_r, count_s;
  logic         ifid_hold_s;
  logic         ifid_flush_s;
  ifid_t        ifid_d_s;
  ifid_t        ifid_q_s;

  // State, PC and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= PC_RESET;
      count_r <= 32'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      count_r <= count_s;
    end
  end

  // Next-state and IF/ID control; redirect outranks stall, stall outranks the limit check.
  always_comb begin
    state_s           = state_r;
    pc_s              = pc_r;
    count_s           = count_r;
    ifid_hold_s       = 1'b1;
    ifid_flush_s      = 1'b0;
    ifid_d_s.valid    = 1'b1;
    ifid_d_s.inst     = imem.imem_inst;
    ifid_d_s.pc       = pc_r;
    ifid_d_s.pc_plus4 = pc_r + INSTR_BYTES;

    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (redirect_i) begin
          ifid_flush_s = 1'b1;
          if (redirect_pc_i[1:0] != 2'b00) begin
            state_s = ST_FAULT;
          end else if (redirect_pc_i >= PC_LIMIT) begin
            state_s = ST_HALT;
          end else begin
            pc_s = redirect_pc_i;
          end
        end else if (stall_i) begin
          ifid_hold_s = 1'b1;
        end else if (pc_r >= PC_LIMIT) begin
          state_s      = ST_HALT;
          ifid_flush_s = 1'b1;
        end else begin
          ifid_hold_s = 1'b0;
          pc_s        = pc_r + INSTR_BYTES;
          count_s     = count_r + 32'd1;
        end
      end
      ST_HALT:  state_s = ST_HALT;
      ST_FAULT: state_s = ST_FAULT;
      default:  state_s = ST_IDLE;
    endcase
  end

  ifid_reg u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (ifid_hold_s),
    .flush (ifid_flush_s),
    .d     (ifid_d_s),
    .q     (ifid_q_s)
  );

  assign imem.imem_addr  = pc_r;
  assign ifid_valid_o    = ifid_q_s.valid;
  assign ifid_inst_o     = ifid_q_s.inst;
  assign ifid_pc_o       = ifid_q_s.pc;
  assign ifid_pc_plus4_o = ifid_q_s.pc_plus4;
  assign halted_o        = (state_r == ST_HALT);
  assign fault_o         = (state_r == ST_FAULT);
  assign fetch_count_o   = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus a free-run halt sequence
// on a second instance with a reduced address limit.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (PC_LIMIT = 64)
  logic        rst_n, start, stall, redirect;
  logic [31:0] redirect_pc;
  logic        valid, halted, fault;
  logic [31:0] inst, pc, pc4, cnt;

  // Reduced-limit instance (PC_LIMIT = 56)
  logic        rst2, start2, stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic        valid2, halted2, fault2;
  logic [31:0] inst2, ipc2, pc42, cnt2;

  fetch_unit_if m0();
  fetch_unit_if m1();

  logic [31:0] mem [0:15];
  assign m0.imem_inst = (m0.imem_addr < 32'd64) ? mem[m0.imem_addr[5:2]] : 32'h0000_0000;
  assign m1.imem_inst = (m1.imem_addr < 32'd64) ? mem[m1.imem_addr[5:2]] : 32'h0000_0000;

  fetch_unit #(.PC_RESET(32'h0000_0000), .PC_LIMIT(32'd64)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stall_i(stall),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .imem(m0),
    .ifid_valid_o(valid), .ifid_inst_o(inst), .ifid_pc_o(pc),
    .ifid_pc_plus4_o(pc4), .halted_o(halted), .fault_o(fault),
    .fetch_count_o(cnt)
  );

  fetch_unit #(.PC_RESET(32'h0000_0000), .PC_LIMIT(32'd56)) dut_lim (
    .clk(clk), .rst_n(rst2), .start_i(start2), .stall_i(stall2),
    .redirect_i(redirect2), .redirect_pc_i(redirect_pc2), .imem(m1),
    .ifid_valid_o(valid2), .ifid_inst_o(inst2), .ifid_pc_o(ipc2),
    .ifid_pc_plus4_o(pc42), .halted_o(halted2), .fault_o(fault2),
    .fetch_count_o(cnt2)
  );

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [31:0] tgt;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic sv(input int i, input logic r, input logic s, input logic st, input logic rd,
                    input logic [31:0] t, input logic v, input logic [31:0] in,
                    input logic [31:0] p, input logic [31:0] a, input logic h,
                    input logic f, input logic [31:0] c);
    vecs[i] = '{r, s, st, rd, t, v, in, p, a, h, f, c};
  endtask

  logic [31:0] last_inst, last_pc;
  logic        done;

  initial begin
    mem[0]  = 32'h0000B037; mem[1]  = 32'hBCD00013; mem[2]  = 32'h0000A023;
    mem[3]  = 32'h00908013; mem[4]  = 32'h00A00093; mem[5]  = 32'h00B00113;
    mem[6]  = 32'h00C00193; mem[7]  = 32'h00D00213; mem[8]  = 32'h06108013;
    mem[9]  = 32'h00E00293; mem[10] = 32'h00F00313; mem[11] = 32'h01000393;
    mem[12] = 32'h01100413; mem[13] = 32'h00000113; mem[14] = 32'h01200493;
    mem[15] = 32'h01300513;

    //  i  rst st  stl rd  target          v     inst           pc             addr           h     f     cnt
    sv(0,  0, 0, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(1,  1, 1, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(2,  1, 0, 0, 0, 32'h0,          1, 32'h0000B037, 32'h00, 32'h04, 0, 0, 32'd1);
    sv(3,  1, 0, 0, 0, 32'h0,          1, 32'hBCD00013, 32'h04, 32'h08, 0, 0, 32'd2);
    sv(4,  1, 0, 0, 0, 32'h0,          1, 32'h0000A023, 32'h08, 32'h0C, 0, 0, 32'd3);
    sv(5,  1, 0, 1, 0, 32'h0,          1, 32'h0000A023, 32'h08, 32'h0C, 0, 0, 32'd3);
    sv(6,  1, 0, 1, 0, 32'h0,          1, 32'h0000A023, 32'h08, 32'h0C, 0, 0, 32'd3);
    sv(7,  1, 0, 1, 0, 32'h0,          1, 32'h0000A023, 32'h08, 32'h0C, 0, 0, 32'd3);
    sv(8,  1, 0, 0, 0, 32'h0,          1, 32'h00908013, 32'h0C, 32'h10, 0, 0, 32'd4);
    sv(9,  1, 0, 1, 1, 32'h20,         0, 32'h00000013, 32'h0C, 32'h20, 0, 0, 32'd4);
    sv(10, 1, 0, 0, 0, 32'h0,          1, 32'h06108013, 32'h20, 32'h24, 0, 0, 32'd5);
    sv(11, 1, 0, 0, 1, 32'h22,         0, 32'h00000013, 32'h20, 32'h24, 0, 1, 32'd5);
    sv(12, 1, 1, 0, 1, 32'h0,          0, 32'h00000013, 32'h20, 32'h24, 0, 1, 32'd5);
    sv(13, 1, 0, 1, 0, 32'h0,          0, 32'h00000013, 32'h20, 32'h24, 0, 1, 32'd5);
    sv(14, 0, 0, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(15, 1, 1, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(16, 1, 0, 0, 0, 32'h0,          1, 32'h0000B037, 32'h00, 32'h04, 0, 0, 32'd1);
    sv(17, 1, 0, 0, 1, 32'h40,         0, 32'h00000013, 32'h00, 32'h04, 1, 0, 32'd1);
    sv(18, 1, 1, 0, 1, 32'h8,          0, 32'h00000013, 32'h00, 32'h04, 1, 0, 32'd1);
    sv(19, 0, 0, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(20, 1, 1, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(21, 1, 0, 0, 0, 32'h0,          1, 32'h0000B037, 32'h00, 32'h04, 0, 0, 32'd1);
    sv(22, 1, 0, 0, 0, 32'h0,          1, 32'hBCD00013, 32'h04, 32'h08, 0, 0, 32'd2);
    sv(23, 1, 0, 0, 0, 32'h0,          1, 32'h0000A023, 32'h08, 32'h0C, 0, 0, 32'd3);
    sv(24, 1, 0, 0, 0, 32'h0,          1, 32'h00908013, 32'h0C, 32'h10, 0, 0, 32'd4);
    sv(25, 1, 0, 0, 0, 32'h0,          1, 32'h00A00093, 32'h10, 32'h14, 0, 0, 32'd5);
    sv(26, 1, 0, 0, 0, 32'h0,          1, 32'h00B00113, 32'h14, 32'h18, 0, 0, 32'd6);
    sv(27, 1, 0, 1, 0, 32'h0,          1, 32'h00B00113, 32'h14, 32'h18, 0, 0, 32'd6);
    sv(28, 0, 0, 1, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);
    sv(29, 1, 0, 0, 0, 32'h0,          0, 32'h00000013, 32'h00, 32'h00, 0, 0, 32'd0);

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rst2 = 1'b0; start2 = 1'b0; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0;

    for (int i = 0; i < NV; i++) begin
      rst_n       = vecs[i].rst_n;
      start       = vecs[i].start;
      stall       = vecs[i].stall;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].tgt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i),  {31'd0, valid},  {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_inst", i),   inst,            vecs[i].inst);
      chk($sformatf("v%0d_pc", i),     pc,              vecs[i].pc);
      chk($sformatf("v%0d_pc4", i),    pc4,             vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_addr", i),   m0.imem_addr,    vecs[i].addr);
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].halted});
      chk($sformatf("v%0d_fault", i),  {31'd0, fault},  {31'd0, vecs[i].fault});
      chk($sformatf("v%0d_count", i),  cnt,             vecs[i].cnt);
    end
    rst_n = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;

    // Free run to the reduced limit on the second instance.
    rst2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2    = 1'b0;
    last_inst = 32'h0;
    last_pc   = 32'hFFFF_FFFF;
    done      = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      if (valid2) begin
        last_inst = inst2;
        last_pc   = ipc2;
        chk($sformatf("lim_fetch_%0d", k), inst2, mem[ipc2[5:2]]);
      end
      if (halted2) done = 1'b1;
    end
    chk("lim_halt_reached", {31'd0, done},    32'd1);
    chk("lim_last_inst",    last_inst,        32'h00000113);
    chk("lim_last_pc",      last_pc,          32'h00000034);
    chk("lim_count",        cnt2,             32'd14);
    chk("lim_valid",        {31'd0, valid2},  32'd0);
    chk("lim_fault",        {31'd0, fault2},  32'd0);
    chk("lim_addr",         m1.imem_addr,     32'h00000038);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("lim_sticky_halt",  {31'd0, halted2}, 32'd1);
    chk("lim_sticky_count", cnt2,             32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
